ysyx_22040750_ifu: RTL and testbench
====================================

# ysyx_22040750_ifu

Instruction fetch unit for the fullpipeline core. It owns the architectural PC register and consumes the next-PC (dnpc) stream through a valid/ready handshake. For each PC it issues one request to instruction memory, captures the response, and presents {pc, snpc, inst} to the IF/ID register through a second valid/ready handshake. Flushes discard the in-flight fetch, and the next accepted dnpc redirects the stream.

## Interface

Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset

Ports:
- I_clk  in  1  clock; all state updates on the rising edge
- I_rst  in  1  reset, asynchronous, active-high
- I_dnpc_valid  in  1  dnpc producer has a valid next PC
- I_dnpc  in  32  next PC value
- O_dnpc_ready  out  1  IFU accepts dnpc this cycle
- O_imem_req_valid  out  1  fetch request valid
- O_imem_addr  out  32  fetch address; equals the PC register
- I_imem_req_ready  in  1  memory accepts the request
- I_imem_rsp_valid  in  1  fetch data valid
- I_imem_rsp_data  in  32  fetched instruction
- I_flush  in  1  discard current fetch/output; wait for a new dnpc
- O_IF_ID_valid  out  1  instruction bundle valid
- I_IF_ID_ready  in  1  IF/ID accepts the bundle
- O_IF_ID_pc  out  32  PC of the bundle
- O_IF_ID_snpc  out  32  pc + 4, modulo 2^32
- O_IF_ID_inst  out  32  instruction; 32'h0000_0013 when misaligned
- O_IF_ID_misalign  out  1  pc[1:0] != 0; no memory access was made

## Operation

States: S_BOOT, S_REQ, S_WAIT, S_DROP, S_OUT, S_PC.

- S_BOOT: the reset state. Advances to S_REQ after one cycle.
- S_REQ: O_imem_req_valid = 1 and O_imem_addr = pc.
  - On I_imem_req_ready, go to S_WAIT, or to S_DROP if a flush is pending or I_flush = 1 this cycle.
  - The request is never withdrawn before acceptance. A flush in S_REQ sets flush_pending and the request stays up.
- S_WAIT: on I_imem_rsp_valid, latch inst and go to S_OUT. If I_flush arrives before the response, go to S_DROP.
- S_DROP: on I_imem_rsp_valid, discard the data, clear flush_pending, and go to S_PC.
- S_OUT: O_IF_ID_valid = 1.
  - On I_IF_ID_ready, go to S_PC.
  - On I_flush, go to S_PC with the bundle dropped. I_flush has priority over I_IF_ID_ready.
  - pc, snpc, inst and misalign are stable while valid is high and ready is low.
- S_PC: O_dnpc_ready = 1. On I_dnpc_valid, load pc <= I_dnpc.
  - If I_dnpc[1:0] == 0, go to S_REQ.
  - Otherwise go to S_OUT with misalign = 1 and inst = 32'h0000_0013, with no imem request.
  - I_flush in S_PC has no effect.
- A response arriving in any state other than S_WAIT or S_DROP is ignored.
- snpc = pc + 32'd4, computed at 32 bits; the carry is discarded.

## Timing

Reset values (asynchronous, while I_rst = 1):
- state = S_BOOT, pc = RESET_PC, inst = 0, misalign = 0, flush_pending = 0.
- All valid/ready outputs are 0.
- O_imem_addr = RESET_PC, O_IF_ID_pc = RESET_PC, O_IF_ID_snpc = RESET_PC + 4.

Latency:
- First request: O_imem_req_valid rises in the 2nd cycle after I_rst deasserts.
- dnpc handshake at cycle t: req_valid at t+1. With req_ready at t+1 and rsp_valid at t+2, O_IF_ID_valid is high at t+3.
- Misaligned dnpc at t: O_IF_ID_valid at t+1.
- Handshakes complete only when valid & ready are sampled high on the same rising edge.
- Outputs are registered or decoded from state only. There is no combinational path from I_dnpc_valid to O_dnpc_ready, or from I_IF_ID_ready to O_IF_ID_valid.
- Reset mid-operation returns to S_BOOT immediately and drops any outstanding fetch. The bench does not return stale responses after reset.

## Test plan

- Reset release, req_ready = 1 and rsp one cycle later with data 32'h00000297 -> addr 0x80000000; bundle pc = 0x80000000, snpc = 0x80000004, inst = 0x00000297, misalign = 0.
- Backpressure: I_IF_ID_ready low for 5 cycles in S_OUT -> valid held and bundle unchanged; O_dnpc_ready stays 0 until the handshake.
- Producer holds dnpc = 0x80000100 valid for 3 cycles before S_PC is reached -> accepted exactly once; next addr = 0x80000100.
- I_flush while in S_REQ with req_ready low for 2 cycles, then rsp 0xDEADBEEF -> request stays up until accepted; response dropped; no bundle output; O_dnpc_ready = 1 next.
- dnpc = 0x80000102 -> no imem request; bundle pc = 0x80000102, inst = 0x00000013, misalign = 1.
- pc = 0xFFFFFFFC -> snpc = 0x00000000; async I_rst asserted in S_WAIT -> all outputs reach reset values before the next clock edge.

Source files
------------

// File: rtl/ysyx_22040750_ifu.sv
// Instruction fetch unit: owns the PC, fetches one instruction per accepted
// dnpc and hands {pc, snpc, inst} to the IF/ID register over valid/ready.
module ysyx_22040750_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_dnpc_valid,
  input  logic [31:0] I_dnpc,
  output logic        O_dnpc_ready,
  output logic        O_imem_req_valid,
  output logic [31:0] O_imem_addr,
  input  logic        I_imem_req_ready,
  input  logic        I_imem_rsp_valid,
  input  logic [31:0] I_imem_rsp_data,
  input  logic        I_flush,
  output logic        O_IF_ID_valid,
  input  logic        I_IF_ID_ready,
  output logic [31:0] O_IF_ID_pc,
  output logic [31:0] O_IF_ID_snpc,
  output logic [31:0] O_IF_ID_inst,
  output logic        O_IF_ID_misalign
);

  typedef enum logic [2:0] {
    S_BOOT, S_REQ, S_WAIT, S_DROP, S_OUT, S_PC
  } state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        misalign;
  logic        flush_pending;

  // A flush never withdraws an issued request; it only marks the response to be discarded.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state         <= S_BOOT;
      pc            <= RESET_PC;
      inst          <= 32'h0;
      misalign      <= 1'b0;
      flush_pending <= 1'b0;
    end else begin
      case (state)
        S_BOOT: state <= S_REQ;
        S_REQ: begin
          if (I_flush) flush_pending <= 1'b1;
          if (I_imem_req_ready)
            state <= (flush_pending || I_flush) ? S_DROP : S_WAIT;
        end
        S_WAIT: begin
          if (I_flush) begin
            if (I_imem_rsp_valid) begin
              state <= S_PC;
            end else begin
              flush_pending <= 1'b1;
              state         <= S_DROP;
            end
          end else if (I_imem_rsp_valid) begin
            inst  <= I_imem_rsp_data;
            state <= S_OUT;
          end
        end
        S_DROP: begin
          if (I_imem_rsp_valid) begin
            flush_pending <= 1'b0;
            state         <= S_PC;
          end
        end
        S_OUT: begin
          if (I_flush || I_IF_ID_ready) state <= S_PC;
        end
        S_PC: begin
          if (I_dnpc_valid) begin
            pc <= I_dnpc;
            if (I_dnpc[1:0] == 2'b00) begin
              misalign <= 1'b0;
              state    <= S_REQ;
            end else begin
              misalign <= 1'b1;
              inst     <= NOP_INST;
              state    <= S_OUT;
            end
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

  assign O_dnpc_ready     = (state == S_PC);
  assign O_imem_req_valid = (state == S_REQ);
  assign O_IF_ID_valid    = (state == S_OUT);
  assign O_imem_addr      = pc;
  assign O_IF_ID_pc       = pc;
  assign O_IF_ID_snpc     = pc + 32'd4;
  assign O_IF_ID_inst     = inst;
  assign O_IF_ID_misalign = misalign;

endmodule

// File: tb/tb_ysyx_22040750_ifu.sv
// Bench for ysyx_22040750_ifu: directed scenarios followed by a randomized run
// checked against a transaction-level model of the fetch stream.
module tb_ysyx_22040750_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b1;
  logic        I_dnpc_valid = 1'b0;
  logic [31:0] I_dnpc = 32'h0;
  logic        O_dnpc_ready;
  logic        O_imem_req_valid;
  logic [31:0] O_imem_addr;
  logic        I_imem_req_ready = 1'b0;
  logic        I_imem_rsp_valid = 1'b0;
  logic [31:0] I_imem_rsp_data = 32'h0;
  logic        I_flush = 1'b0;
  logic        O_IF_ID_valid;
  logic        I_IF_ID_ready = 1'b0;
  logic [31:0] O_IF_ID_pc;
  logic [31:0] O_IF_ID_snpc;
  logic [31:0] O_IF_ID_inst;
  logic        O_IF_ID_misalign;

  int errors = 0;
  int checks = 0;

  ysyx_22040750_ifu #(.RESET_PC(RESET_PC)) dut (
    .I_clk(I_clk), .I_rst(I_rst),
    .I_dnpc_valid(I_dnpc_valid), .I_dnpc(I_dnpc), .O_dnpc_ready(O_dnpc_ready),
    .O_imem_req_valid(O_imem_req_valid), .O_imem_addr(O_imem_addr),
    .I_imem_req_ready(I_imem_req_ready), .I_imem_rsp_valid(I_imem_rsp_valid),
    .I_imem_rsp_data(I_imem_rsp_data), .I_flush(I_flush),
    .O_IF_ID_valid(O_IF_ID_valid), .I_IF_ID_ready(I_IF_ID_ready),
    .O_IF_ID_pc(O_IF_ID_pc), .O_IF_ID_snpc(O_IF_ID_snpc),
    .O_IF_ID_inst(O_IF_ID_inst), .O_IF_ID_misalign(O_IF_ID_misalign)
  );

  always #5 I_clk = ~I_clk;

  // Synthetic memory contents used by the randomized run.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task test_reset();
    I_rst = 1'b1;
    #12;
    checks++;
    if ({O_dnpc_ready, O_imem_req_valid, O_IF_ID_valid, O_IF_ID_misalign} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b want 0000",
               {O_dnpc_ready, O_imem_req_valid, O_IF_ID_valid, O_IF_ID_misalign});
    end
    checks++;
    if ({O_imem_addr, O_IF_ID_pc, O_IF_ID_snpc, O_IF_ID_inst} !==
        {RESET_PC, RESET_PC, RESET_PC + 32'd4, 32'h0}) begin
      errors++;
      $display("[TB] FAIL reset_values: addr=%h pc=%h snpc=%h inst=%h want %h %h %h 0",
               O_imem_addr, O_IF_ID_pc, O_IF_ID_snpc, O_IF_ID_inst,
               RESET_PC, RESET_PC, RESET_PC + 32'd4);
    end
    @(posedge I_clk);
    #1 I_rst = 1'b0;
    @(negedge I_clk);
    checks++;
    if (O_imem_req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL boot_cycle_req: got %b want 0", O_imem_req_valid);
    end
    @(negedge I_clk);
    checks++;
    if (O_imem_req_valid !== 1'b1 || O_imem_addr !== RESET_PC) begin
      errors++;
      $display("[TB] FAIL first_req: valid=%b addr=%h want 1 %h", O_imem_req_valid, O_imem_addr, RESET_PC);
    end
  endtask

  task test_basic_fetch();
    I_imem_req_ready = 1'b1;
    @(negedge I_clk);
    I_imem_req_ready = 1'b0;
    I_imem_rsp_valid = 1'b1;
    I_imem_rsp_data  = 32'h0000_0297;
    @(negedge I_clk);
    I_imem_rsp_valid = 1'b0;
    I_imem_rsp_data  = 32'hFFFF_FFFF;
    checks++;
    if ({O_IF_ID_valid, O_IF_ID_pc, O_IF_ID_snpc, O_IF_ID_inst, O_IF_ID_misalign} !==
        {1'b1, 32'h8000_0000, 32'h8000_0004, 32'h0000_0297, 1'b0}) begin
      errors++;
      $display("[TB] FAIL basic_bundle: v=%b pc=%h snpc=%h inst=%h mis=%b want 1 80000000 80000004 00000297 0",
               O_IF_ID_valid, O_IF_ID_pc, O_IF_ID_snpc, O_IF_ID_inst, O_IF_ID_misalign);
    end
  endtask

  // Holds the bundle for 5 cycles while a dnpc producer waits with its value up.
  task test_backpressure_and_dnpc_hold();
    I_IF_ID_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i >= 2) begin
        I_dnpc_valid = 1'b1;
        I_dnpc       = 32'h8000_0100;
      end
      @(negedge I_clk);
      checks++;
      if ({O_IF_ID_valid, O_dnpc_ready, O_IF_ID_pc, O_IF_ID_inst} !==
          {1'b1, 1'b0, 32'h8000_0000, 32'h0000_0297}) begin
        errors++;
        $display("[TB] FAIL backpressure_hold[%0d]: v=%b dr=%b pc=%h inst=%h want 1 0 80000000 00000297",
                 i, O_IF_ID_valid, O_dnpc_ready, O_IF_ID_pc, O_IF_ID_inst);
      end
    end
    I_IF_ID_ready = 1'b1;
    @(negedge I_clk);
    I_IF_ID_ready = 1'b0;
    checks++;
    if (O_dnpc_ready !== 1'b1 || O_IF_ID_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release_to_pc: dr=%b v=%b want 1 0", O_dnpc_ready, O_IF_ID_valid);
    end
    @(negedge I_clk);
    I_dnpc = 32'h8000_0200;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({O_imem_req_valid, O_dnpc_ready, O_imem_addr} !== {1'b1, 1'b0, 32'h8000_0100}) begin
        errors++;
        $display("[TB] FAIL dnpc_once[%0d]: req=%b dr=%b addr=%h want 1 0 80000100",
                 i, O_imem_req_valid, O_dnpc_ready, O_imem_addr);
      end
      @(negedge I_clk);
    end
    I_dnpc_valid = 1'b0;
  endtask

  task test_flush_in_req();
    I_flush = 1'b1;
    @(negedge I_clk);
    I_flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (O_imem_req_valid !== 1'b1 || O_imem_addr !== 32'h8000_0100) begin
        errors++;
        $display("[TB] FAIL flush_req_held[%0d]: req=%b addr=%h want 1 80000100", i, O_imem_req_valid, O_imem_addr);
      end
      if (i == 1) I_imem_req_ready = 1'b1;
      @(negedge I_clk);
    end
    I_imem_req_ready = 1'b0;
    I_imem_rsp_valid = 1'b1;
    I_imem_rsp_data  = 32'hDEAD_BEEF;
    checks++;
    if ({O_imem_req_valid, O_IF_ID_valid, O_dnpc_ready} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL flush_drop_state: req=%b v=%b dr=%b want 000", O_imem_req_valid, O_IF_ID_valid, O_dnpc_ready);
    end
    @(negedge I_clk);
    I_imem_rsp_valid = 1'b0;
    checks++;
    if (O_dnpc_ready !== 1'b1 || O_IF_ID_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_done: dr=%b v=%b want 1 0", O_dnpc_ready, O_IF_ID_valid);
    end
  endtask

  task test_misalign();
    I_dnpc_valid = 1'b1;
    I_dnpc       = 32'h8000_0102;
    @(negedge I_clk);
    I_dnpc_valid = 1'b0;
    checks++;
    if ({O_IF_ID_valid, O_imem_req_valid, O_IF_ID_pc, O_IF_ID_snpc, O_IF_ID_inst, O_IF_ID_misalign} !==
        {1'b1, 1'b0, 32'h8000_0102, 32'h8000_0106, 32'h0000_0013, 1'b1}) begin
      errors++;
      $display("[TB] FAIL misalign_bundle: v=%b req=%b pc=%h snpc=%h inst=%h mis=%b want 1 0 80000102 80000106 00000013 1",
               O_IF_ID_valid, O_imem_req_valid, O_IF_ID_pc, O_IF_ID_snpc, O_IF_ID_inst, O_IF_ID_misalign);
    end
    I_IF_ID_ready = 1'b1;
    @(negedge I_clk);
    I_IF_ID_ready = 1'b0;
  endtask

  task test_wrap_and_async_reset();
    I_dnpc_valid = 1'b1;
    I_dnpc       = 32'hFFFF_FFFC;
    @(negedge I_clk);
    I_dnpc_valid = 1'b0;
    checks++;
    if (O_imem_addr !== 32'hFFFF_FFFC || O_IF_ID_snpc !== 32'h0000_0000) begin
      errors++;
      $display("[TB] FAIL snpc_wrap: addr=%h snpc=%h want fffffffc 00000000", O_imem_addr, O_IF_ID_snpc);
    end
    I_imem_req_ready = 1'b1;
    @(negedge I_clk);
    I_imem_req_ready = 1'b0;
    #1 I_rst = 1'b1;
    #1;
    checks++;
    if ({O_dnpc_ready, O_imem_req_valid, O_IF_ID_valid, O_IF_ID_misalign,
         O_imem_addr, O_IF_ID_pc, O_IF_ID_snpc, O_IF_ID_inst} !==
        {4'b0000, RESET_PC, RESET_PC, RESET_PC + 32'd4, 32'h0}) begin
      errors++;
      $display("[TB] FAIL async_reset: dr=%b req=%b v=%b mis=%b addr=%h pc=%h snpc=%h inst=%h",
               O_dnpc_ready, O_imem_req_valid, O_IF_ID_valid, O_IF_ID_misalign,
               O_imem_addr, O_IF_ID_pc, O_IF_ID_snpc, O_IF_ID_inst);
    end
    @(posedge I_clk);
    #1 I_rst = 1'b0;
  endtask

  // The model tracks one fetch at a time: its pc, whether it is still live
  // (not flushed or delivered), whether its request/response are outstanding.
  task test_random();
    logic [31:0] m_pc;
    logic [31:0] mem_addr;
    logic [31:0] d;
    logic        live, mis, req_out, have_data, mem_busy;
    int          mem_delay;
    int          idle;
    m_pc = RESET_PC; live = 1'b1; mis = 1'b0; req_out = 1'b1; have_data = 1'b0;
    mem_busy = 1'b0; mem_delay = 0; idle = 0; mem_addr = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge I_clk);
      if (O_imem_req_valid) begin
        checks++;
        if (!req_out || O_imem_addr !== m_pc) begin
          errors++;
          $display("[TB] FAIL rand_req cyc=%0d: addr=%h want %h expected_req=%b", cyc, O_imem_addr, m_pc, req_out);
        end
      end
      if (O_IF_ID_valid) begin
        checks++;
        if (!live || !have_data || O_IF_ID_pc !== m_pc || O_IF_ID_snpc !== m_pc + 32'd4 ||
            O_IF_ID_inst !== (mis ? 32'h0000_0013 : mem_word(m_pc)) || O_IF_ID_misalign !== mis) begin
          errors++;
          $display("[TB] FAIL rand_bundle cyc=%0d: pc=%h snpc=%h inst=%h mis=%b want live=%b data=%b pc=%h inst=%h mis=%b",
                   cyc, O_IF_ID_pc, O_IF_ID_snpc, O_IF_ID_inst, O_IF_ID_misalign,
                   live, have_data, m_pc, mis ? 32'h0000_0013 : mem_word(m_pc), mis);
        end
      end
      if (O_dnpc_ready) begin
        idle = 0;
        checks++;
        if (live || req_out || mem_busy) begin
          errors++;
          $display("[TB] FAIL rand_dnpc_ready cyc=%0d: got 1 want 0 (live=%b req=%b mem=%b)", cyc, live, req_out, mem_busy);
        end
      end else begin
        idle++;
        if (idle > 100) begin
          errors++;
          checks++;
          $display("[TB] FAIL rand_timeout cyc=%0d: dnpc_ready low for %0d cycles want <=100", cyc, idle);
          break;
        end
      end

      I_flush          = (cyc != 0) && ($urandom_range(0, 11) == 0);
      I_imem_req_ready = 1'($urandom_range(0, 1));
      I_IF_ID_ready    = 1'($urandom_range(0, 1));
      I_dnpc_valid     = ($urandom_range(0, 2) != 0);
      d = $urandom;
      case ($urandom_range(0, 3))
        0:       d[1:0] = 2'($urandom_range(1, 3));
        1:       d = 32'hFFFF_FFFC;
        default: d[1:0] = 2'b00;
      endcase
      I_dnpc = d;
      if (mem_busy && mem_delay == 0) begin
        I_imem_rsp_valid = 1'b1;
        I_imem_rsp_data  = mem_word(mem_addr);
      end else begin
        I_imem_rsp_valid = !mem_busy && (O_imem_req_valid || O_IF_ID_valid || O_dnpc_ready) &&
                           ($urandom_range(0, 3) == 0);
        I_imem_rsp_data  = $urandom;
      end

      if (mem_busy) begin
        if (mem_delay == 0) begin
          mem_busy  = 1'b0;
          have_data = 1'b1;
        end else begin
          mem_delay--;
        end
      end
      if (O_dnpc_ready && I_dnpc_valid) begin
        m_pc      = I_dnpc;
        live      = 1'b1;
        mis       = (I_dnpc[1:0] != 2'b00);
        req_out   = !mis;
        have_data = mis;
      end else if (!O_dnpc_ready && I_flush) begin
        live = 1'b0;
      end
      if (O_imem_req_valid && I_imem_req_ready) begin
        req_out   = 1'b0;
        mem_busy  = 1'b1;
        mem_delay = $urandom_range(0, 3);
        mem_addr  = m_pc;
      end
      if (O_IF_ID_valid && I_IF_ID_ready && !I_flush) live = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_backpressure_and_dnpc_hold();
    test_flush_in_req();
    test_misalign();
    test_wrap_and_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
